// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the load/store unit
package mem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, load extension and access legality
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        i_addr_lo,
  input  logic [2:0]        i_funct3,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [XLEN-1:0]   i_store_data,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN/8-1:0] o_be,
  output logic [XLEN-1:0]   o_load_data,
  output logic              o_misaligned,
  output logic              o_illegal
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  logic [1:0]      w_size;
  logic            w_unsigned;
  logic [7:0]      w_be_base;
  logic [2:0]      w_align_mask;
  logic [LW-1:0]   w_lane;
  logic [6:0]      w_bits;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_keep;
  logic [XLEN-1:0] w_sign_pos;
  logic            w_sign;
  logic            w_size_bad;
  logic            w_load_bad;
  logic            w_store_bad;

  assign w_lane = i_addr_lo[LW-1:0];

  always_comb begin
    w_size     = 2'd0;
    w_unsigned = 1'b0;
    case (i_funct3)
      F3_B:    begin w_size = 2'd0; w_unsigned = 1'b0; end
      F3_H:    begin w_size = 2'd1; w_unsigned = 1'b0; end
      F3_W:    begin w_size = 2'd2; w_unsigned = 1'b0; end
      F3_D:    begin w_size = 2'd3; w_unsigned = 1'b0; end
      F3_BU:   begin w_size = 2'd0; w_unsigned = 1'b1; end
      F3_HU:   begin w_size = 2'd1; w_unsigned = 1'b1; end
      F3_WU:   begin w_size = 2'd2; w_unsigned = 1'b1; end
      default: begin w_size = 2'd0; w_unsigned = 1'b1; end
    endcase
  end

  always_comb begin
    w_be_base    = 8'h01;
    w_align_mask = 3'b000;
    case (w_size)
      2'd0:    begin w_be_base = 8'h01; w_align_mask = 3'b000; end
      2'd1:    begin w_be_base = 8'h03; w_align_mask = 3'b001; end
      2'd2:    begin w_be_base = 8'h0F; w_align_mask = 3'b011; end
      default: begin w_be_base = 8'hFF; w_align_mask = 3'b111; end
    endcase
  end

  assign o_wdata = i_store_data << {w_lane, 3'b000};
  assign o_be    = w_be_base[NB-1:0] << w_lane;

  // Shifts of XLEN or more yield zero, so a full-width access keeps every bit.
  assign w_bits      = 7'd8 << w_size;
  assign w_shifted   = i_rdata >> {w_lane, 3'b000};
  assign w_keep      = ~({XLEN{1'b1}} << w_bits);
  assign w_sign_pos  = {{(XLEN-1){1'b0}}, 1'b1} << (w_bits - 7'd1);
  assign w_sign      = !w_unsigned && (|(w_shifted & w_sign_pos));
  assign o_load_data = (w_shifted & w_keep) | ({XLEN{w_sign}} & ~w_keep);

  assign o_misaligned = |(i_addr_lo & w_align_mask);

  assign w_size_bad  = (XLEN == 32) && ((i_funct3 == F3_D) || (i_funct3 == F3_WU));
  assign w_load_bad  = i_mem_read && (i_funct3 == F3_BAD);
  assign w_store_bad = i_mem_write && (i_funct3 >= F3_BU);
  assign o_illegal   = (i_mem_read && i_mem_write)
                     || ((i_mem_read || i_mem_write) && (w_size_bad || w_load_bad || w_store_bad));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - one load/store per transaction over a req/gnt/rvalid data port
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int DEBUG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  output logic              out_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam int         NB      = XLEN / 8;
  localparam int         LW      = $clog2(NB);
  localparam logic [9:0] LP_LAST = 10'(TIMEOUT - 1);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("mem_access_unit: XLEN must be 32 or 64");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be 1..1023");
  end
  if (DEBUG != 0 && DEBUG != 1) begin : g_bad_debug
    $error("mem_access_unit: DEBUG must be 0 or 1");
  end

  state_t          r_state;
  state_t          w_next_state;
  logic [9:0]      r_cnt;
  logic            r_is_load;
  logic [2:0]      r_funct3;
  logic [2:0]      r_addr_lo;
  logic            r_out_valid;
  logic [XLEN-1:0] r_load_data;
  logic            r_fault;
  logic [1:0]      r_fault_cause;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [XLEN-1:0] r_dmem_addr;
  logic [XLEN-1:0] r_dmem_wdata;
  logic [NB-1:0]   r_dmem_be;

  logic            w_idle;
  logic            w_accept;
  logic            w_noop;
  logic            w_fault_now;
  logic            w_expired;
  logic [2:0]      w_sel_addr_lo;
  logic [2:0]      w_sel_funct3;
  logic [XLEN-1:0] w_wdata;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_load_ext;
  logic            w_misaligned;
  logic            w_illegal;
  logic            w_complete;
  logic            w_cmp_fault;
  logic [1:0]      w_cmp_cause;
  logic [XLEN-1:0] w_cmp_data;

  // Lane logic serves the incoming request while idle and the held request afterwards.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_sel_addr_lo = w_idle ? addr[2:0] : r_addr_lo;
  assign w_sel_funct3  = w_idle ? funct3 : r_funct3;
  assign w_accept      = in_valid && w_idle;
  assign w_noop        = !mem_read && !mem_write;
  assign w_fault_now   = w_illegal || (w_misaligned && !w_noop);
  assign w_expired     = (r_cnt == LP_LAST);

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .i_addr_lo    (w_sel_addr_lo),
    .i_funct3     (w_sel_funct3),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_store_data (store_data),
    .i_rdata      (dmem_rdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_load_data  (w_load_ext),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_next_state = (w_fault_now || w_noop) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          w_next_state = r_is_load ? ST_RWAIT : ST_DONE;
        end else if (w_expired) begin
          w_next_state = ST_DONE;
        end
      end
      ST_RWAIT: begin
        if (dmem_rvalid || w_expired) begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = w_idle;
    w_complete  = 1'b0;
    w_cmp_fault = 1'b0;
    w_cmp_cause = CAUSE_NONE;
    w_cmp_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_illegal) begin
            w_complete  = 1'b1;
            w_cmp_fault = 1'b1;
            w_cmp_cause = CAUSE_ILLEGAL;
          end else if (w_misaligned && !w_noop) begin
            w_complete  = 1'b1;
            w_cmp_fault = 1'b1;
            w_cmp_cause = CAUSE_MISALIGN;
          end else if (w_noop) begin
            w_complete  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          w_complete = !r_is_load;
        end else if (w_expired) begin
          w_complete  = 1'b1;
          w_cmp_fault = 1'b1;
          w_cmp_cause = CAUSE_TIMEOUT;
        end
      end
      ST_RWAIT: begin
        if (dmem_rvalid) begin
          w_complete = 1'b1;
          w_cmp_data = w_load_ext;
        end else if (w_expired) begin
          w_complete  = 1'b1;
          w_cmp_fault = 1'b1;
          w_cmp_cause = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_is_load     <= 1'b0;
      r_funct3      <= '0;
      r_addr_lo     <= '0;
      r_out_valid   <= 1'b0;
      r_load_data   <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_wdata  <= '0;
      r_dmem_be     <= '0;
    end else begin
      r_out_valid <= w_complete;
      r_dmem_req  <= (w_next_state == ST_REQ);
      if (w_complete) begin
        r_load_data   <= w_cmp_data;
        r_fault       <= w_cmp_fault;
        r_fault_cause <= w_cmp_cause;
      end
      // Restart the watchdog on every state change so REQ and RWAIT each get a full budget.
      if (r_state != w_next_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_REQ || r_state == ST_RWAIT) begin
        r_cnt <= r_cnt + 10'd1;
      end
      if (w_accept) begin
        r_is_load    <= mem_read;
        r_funct3     <= funct3;
        r_addr_lo    <= addr[2:0];
        r_dmem_we    <= mem_write;
        r_dmem_addr  <= {addr[XLEN-1:LW], {LW{1'b0}}};
        r_dmem_wdata <= w_wdata;
        r_dmem_be    <= w_be;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign load_data   = r_load_data;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign dmem_addr   = r_dmem_addr;
  assign dmem_wdata  = r_dmem_wdata;
  assign dmem_be     = r_dmem_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        out_valid;
  logic [63:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .TIMEOUT(8), .DEBUG(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .addr        (addr),
    .store_data  (store_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .out_valid   (out_valid),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("issue_ready", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = d;
    @(negedge clk);
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rdata, input logic [63:0] exp);
    issue(1'b1, 1'b0, f3, a, 64'h0);
    check_eq({tag, "_req"}, 64'(dmem_req), 64'd1);
    check_eq({tag, "_we"}, 64'(dmem_we), 64'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq({tag, "_early"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_req_off"}, 64'(dmem_req), 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_fault"}, 64'(fault), 64'd0);
    check_eq({tag, "_data"}, load_data, exp);
    @(negedge clk);
  endtask

  task automatic do_fault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic exp_fault, input logic [1:0] exp_cause);
    issue(rd, wr, f3, a, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_fault"}, 64'(fault), 64'(exp_fault));
    check_eq({tag, "_cause"}, 64'(fault_cause), 64'(exp_cause));
    check_eq({tag, "_req"}, 64'(dmem_req), 64'd0);
    check_eq({tag, "_data"}, load_data, 64'd0);
    @(negedge clk);
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    addr        = '0;
    store_data  = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_load_data", load_data, 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_cause", 64'(fault_cause), 64'd0);
    check_eq("rst_req", 64'(dmem_req), 64'd0);
    check_eq("rst_we", 64'(dmem_we), 64'd0);
    check_eq("rst_addr", dmem_addr, 64'd0);
    check_eq("rst_wdata", dmem_wdata, 64'd0);
    check_eq("rst_be", 64'(dmem_be), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SD, gnt at T+1, completion at T+2
    issue(1'b0, 1'b1, 3'b011, 64'h100, 64'h1122334455667788);
    check_eq("sd_req", 64'(dmem_req), 64'd1);
    check_eq("sd_we", 64'(dmem_we), 64'd1);
    check_eq("sd_be", 64'(dmem_be), 64'hFF);
    check_eq("sd_addr", dmem_addr, 64'h100);
    check_eq("sd_wdata", dmem_wdata, 64'h1122334455667788);
    check_eq("sd_busy", 64'(in_ready), 64'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("sd_valid", 64'(out_valid), 64'd1);
    check_eq("sd_fault", 64'(fault), 64'd0);
    check_eq("sd_req_off", 64'(dmem_req), 64'd0);
    check_eq("sd_busy_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_eq("sd_pulse", 64'(out_valid), 64'd0);
    check_eq("sd_ready", 64'(in_ready), 64'd1);

    // SB into lane 3
    issue(1'b0, 1'b1, 3'b000, 64'h103, 64'h00000000000000AB);
    check_eq("sb_addr", dmem_addr, 64'h100);
    check_eq("sb_be", 64'(dmem_be), 64'h08);
    check_eq("sb_wdata", dmem_wdata, 64'h00000000AB000000);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("sb_valid", 64'(out_valid), 64'd1);
    check_eq("sb_ldata", load_data, 64'd0);
    @(negedge clk);

    // SH into lane 6
    issue(1'b0, 1'b1, 3'b001, 64'h206, 64'h000000000000BEEF);
    check_eq("sh_be", 64'(dmem_be), 64'hC0);
    check_eq("sh_wdata", dmem_wdata, 64'hBEEF000000000000);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("sh_valid", 64'(out_valid), 64'd1);
    @(negedge clk);

    do_load("lb",  3'b000, 64'h105, 64'h0000800000000000, 64'hFFFFFFFFFFFFFF80);
    do_load("lbu", 3'b100, 64'h105, 64'h0000800000000000, 64'h0000000000000080);
    do_load("lbp", 3'b000, 64'h100, 64'h000000000000007F, 64'h000000000000007F);
    do_load("lh",  3'b001, 64'h106, 64'h8001000000000000, 64'hFFFFFFFFFFFF8001);
    do_load("lhu", 3'b101, 64'h106, 64'h8001000000000000, 64'h0000000000008001);
    do_load("lw",  3'b010, 64'h104, 64'h89ABCDEF00000000, 64'hFFFFFFFF89ABCDEF);
    do_load("lwu", 3'b110, 64'h104, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF);
    do_load("ld",  3'b011, 64'h108, 64'h8877665544332211, 64'h8877665544332211);

    do_fault("lw_mis",  1'b1, 1'b0, 3'b010, 64'h102, 1'b1, 2'b01);
    do_fault("lh_mis",  1'b1, 1'b0, 3'b001, 64'h101, 1'b1, 2'b01);
    do_fault("sd_mis",  1'b0, 1'b1, 3'b011, 64'h104, 1'b1, 2'b01);
    do_fault("rw_ill",  1'b1, 1'b1, 3'b010, 64'h100, 1'b1, 2'b10);
    do_fault("rw_prio", 1'b1, 1'b1, 3'b001, 64'h101, 1'b1, 2'b10);
    do_fault("ld_111",  1'b1, 1'b0, 3'b111, 64'h100, 1'b1, 2'b10);
    do_fault("sbu_ill", 1'b0, 1'b1, 3'b100, 64'h100, 1'b1, 2'b10);
    do_fault("noop",    1'b0, 1'b0, 3'b010, 64'h103, 1'b0, 2'b00);

    // Watchdog: gnt never arrives
    issue(1'b0, 1'b1, 3'b010, 64'h100, 64'h12345678);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("to_req%0d", i), 64'(dmem_req), 64'd1);
      check_eq($sformatf("to_idle%0d", i), 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check_eq("to_valid", 64'(out_valid), 64'd1);
    check_eq("to_fault", 64'(fault), 64'd1);
    check_eq("to_cause", 64'(fault_cause), 64'd3);
    check_eq("to_req_off", 64'(dmem_req), 64'd0);
    @(negedge clk);

    // Stray gnt while idle does nothing
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("gnt_idle_req", 64'(dmem_req), 64'd0);
    check_eq("gnt_idle_valid", 64'(out_valid), 64'd0);

    // Reset during REQ drops dmem_req without a clock edge
    issue(1'b1, 1'b0, 3'b011, 64'h200, 64'h0);
    check_eq("rreq_req", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rreq_req_async", 64'(dmem_req), 64'd0);
    check_eq("rreq_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during RWAIT, then a stale rvalid
    issue(1'b1, 1'b0, 3'b000, 64'h108, 64'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rwait_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stale_valid%0d", i), 64'(out_valid), 64'd0);
      check_eq($sformatf("stale_ready%0d", i), 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    do_load("ld_after", 3'b011, 64'h200, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised successor to the single-cycle memory stage. Executes one RISC-V load/store per transaction:
- supports all widths (B/H/W/D) with sign/zero extension, byte-lane steering and alignment checking;
- talks to data memory over a req/gnt/rvalid handshake with variable latency and a bus-timeout watchdog;
- sits between execute and writeback and stalls the core via `in_ready`/`out_valid`.

## Interface
- `XLEN`, 64: data/address width, 32 or 64.
- `TIMEOUT`, 255: max cycles waiting on `dmem_gnt` or `dmem_rvalid` before fault, 1..1023.
- `DEBUG`, 0: when 1, `$display` each store/load/fault at completion.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit idle, request accepted when `in_valid && in_ready`.
- `addr` in XLEN: byte address (ALU result).
- `store_data` in XLEN: rs2 value.
- `mem_read`, `mem_write` in 1 each: operation select.
- `funct3` in 3: size/sign. Encodings: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `out_valid` out 1: one-cycle completion pulse.
- `load_data` out XLEN: extended load result, 0 for stores, faults and no-ops.
- `fault` out 1: transaction faulted, valid with `out_valid`.
- `fault_cause` out 2: 01 misaligned, 10 illegal (read&write both set, size D or WU with XLEN=32, funct3=111 on a load, funct3≥100 on a store), 11 timeout.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write.
- `dmem_addr` out XLEN: address aligned down to XLEN/8.
- `dmem_wdata` out XLEN: lane-shifted store data.
- `dmem_be` out XLEN/8: byte enables.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in XLEN: read data (full aligned word).

## Operation
- FSM states: IDLE, REQ, RWAIT, DONE.
- IDLE: `in_ready`=1. On accept, register all inputs.
  - Fault detected, or neither read nor write: go to DONE (no memory access).
  - Otherwise: go to REQ.
- REQ: `dmem_req`=1, with address/we/wdata/be held stable.
  - On `dmem_gnt`: a store goes to DONE; a load goes to RWAIT.
- RWAIT: `dmem_req`=0. On `dmem_rvalid`, capture the extracted, extended data and go to DONE.
- DONE: `out_valid`=1 for one cycle, then IDLE.
- Watchdog counter: reset on entering REQ and on entering RWAIT, incremented each cycle in those states. Reaching TIMEOUT goes to DONE with cause 11 and drops `dmem_req`.
- Alignment: address low bits must be zero for the access size (H:1, W:2, D:3 bits).
- Lane index is `addr[log2(XLEN/8)-1:0]`.
  - Store: data shifted left by lane*8; `be` = size mask << lane.
  - Load: `rdata` shifted right by lane*8, then sign- or zero-extended per funct3.
- Both read and write set: cause 10, with priority over misaligned.
- `dmem_rvalid` outside RWAIT, and `dmem_gnt` outside REQ, are ignored.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `load_data`=0, `fault`=0, `fault_cause`=00, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0. FSM in IDLE, counter 0.
- All outputs are registered, except that `in_ready` decodes the state.
- Latency, with accept at cycle T:
  - fault or no-op: `out_valid` at T+1;
  - store with gnt at T+1: `out_valid` at T+2;
  - load with gnt at T+1 and rvalid at T+2: `out_valid` at T+3.
- `in_ready` is 0 from T+1 until the cycle after `out_valid`, so back-to-back accepts are spaced at least 2 cycles apart.
- `rst_n` assertion mid-transaction: immediate return to IDLE, `dmem_req` drops asynchronously, the transaction is lost with no `out_valid`. A stale rvalid after release is ignored.

## Structure
- Package `mem_pkg`: funct3 size constants, fault cause codes, FSM state enum.
- Sub-module `mem_lane_align` (combinational, parametrised by XLEN) holds:
  - store shift and byte-enable generation;
  - load extract and sign/zero extension;
  - misaligned and illegal-size detection.
- The FSM, watchdog and output registers live in `mem_access_unit`.

## Test plan
- SD 0x1122334455667788 @0x100, gnt at T+1: `dmem_be`=0xFF, `dmem_addr`=0x100, `out_valid` at T+2, `fault`=0.
- SB 0xAB @0x103: `dmem_addr`=0x100, `dmem_be`=0x08, `dmem_wdata[31:24]`=0xAB.
- LB @0x105 with `rdata`=0x0000800000000000: `load_data`=0xFFFFFFFFFFFFFF80. LBU on the same data: 0x80.
- LW @0x102: `out_valid` at T+1 with `fault_cause`=01, `dmem_req` never asserted. Both mem_read and mem_write set: cause 10.
- TIMEOUT=8, gnt held low: `dmem_req` high for 8 cycles, then `out_valid`, cause 11, `dmem_req`=0.
- `rst_n` pulsed low in RWAIT, then rvalid after release: no `out_valid`, `in_ready`=1, next LD @0x200 completes normally.
